// File: rtl/wb_regfile.sv
// Write-back stage register file: selects the WB result, commits it into the
// integer register file, and serves two decode read ports plus a debug port.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int BYPASS = 1,
  parameter int CNTW  = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] ALUResultW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic [AW-1:0]   RdW,
  input  logic [AW-1:0]   Rs1D,
  input  logic [AW-1:0]   Rs2D,
  input  logic [AW-1:0]   DbgAddr,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [XLEN-1:0] DbgData,
  output logic [XLEN-1:0] ResultW,
  output logic [CNTW-1:0] WriteCount
);

  logic [XLEN-1:0] regs [NREGS];
  logic [CNTW-1:0] write_count;
  logic            commit;
  logic            bypass_en;

  // Encoding 11 is reserved and deliberately aliases the ALU result.
  always_comb begin
    ResultW = ALUResultW;
    case (ResultSrcW)
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = ALUResultW;
    endcase
  end

  // Gating on rst_n also keeps the bypass path closed while in reset.
  assign commit    = rst_n && RegWriteW && (RdW != '0);
  assign bypass_en = (BYPASS != 0) && commit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      write_count <= '0;
    end else if (commit) begin
      regs[RdW]   <= ResultW;
      write_count <= write_count + CNTW'(1);
    end
  end

  always_comb begin
    RD1D = regs[Rs1D];
    if (Rs1D == '0)
      RD1D = '0;
    else if (bypass_en && (Rs1D == RdW))
      RD1D = ResultW;
  end

  always_comb begin
    RD2D = regs[Rs2D];
    if (Rs2D == '0)
      RD2D = '0;
    else if (bypass_en && (Rs2D == RdW))
      RD2D = ResultW;
  end

  // The debug port always shows stored state, never the in-flight write.
  always_comb begin
    DbgData = regs[DbgAddr];
    if (DbgAddr == '0) DbgData = '0;
  end

  assign WriteCount = write_count;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface.
- Takes the WB-stage register outputs, selects the write-back result, and commits it into a 32-entry integer register file.
- Serves two combinational read ports to the decode stage and a debug read port.
- Keeps a committed-write counter.
- Sits between the MEM/WB pipeline register, the ID stage, and the forwarding unit.

Parameters:
- XLEN, 32, data width of registers and results
- NREGS, 32, number of architectural registers (address width = log2(NREGS) = 5)
- BYPASS, 1, when 1, a read of the register being written this cycle returns the new value
- CNTW, 32, width of committed-write counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- RegWriteW  input  1  write enable from MEM/WB
- ResultSrcW  input  2  result select from MEM/WB
- ReadDataW  input  XLEN  load data from MEM/WB
- ALUResultW  input  XLEN  ALU result from MEM/WB
- PCPlus4W  input  XLEN  PC+4 from MEM/WB
- RdW  input  5  destination register from MEM/WB
- Rs1D  input  5  read address port 1 (decode)
- Rs2D  input  5  read address port 2 (decode)
- DbgAddr  input  5  debug read address
- RD1D  output  XLEN  read data port 1
- RD2D  output  XLEN  read data port 2
- DbgData  output  XLEN  debug read data (no bypass)
- ResultW  output  XLEN  selected write-back value (to forwarding unit)
- WriteCount  output  CNTW  number of committed writes since reset

Behaviour:
- Reset: sampled only on rising clk edge with rst_n=0.
  - All NREGS entries clear to 0 and WriteCount clears to 0.
  - No write commits on that edge, regardless of RegWriteW.
  - While rst_n=0, bypass is disabled, so RD1D/RD2D reflect array contents only.
- Result mux (combinational):
  - ResultSrcW=00 → ALUResultW
  - 01 → ReadDataW
  - 10 → PCPlus4W
  - 11 → ALUResultW (reserved encoding, defined as ALU)
- Commit condition: rst_n=1 AND RegWriteW=1 AND RdW≠0.
  - On the rising edge, reg[RdW] ← ResultW and WriteCount increments by 1.
  - Counter wraps modulo 2^CNTW silently; all-ones + 1 → 0.
- x0:
  - Always reads 0 on every port.
  - Writes to x0 are dropped and not counted, even with RegWriteW=1.
- Reads (combinational, zero latency):
  - RDnD = 0 if address=0.
  - Otherwise, if BYPASS=1 and the commit condition holds and address=RdW, RDnD = ResultW.
  - Otherwise, RDnD = reg[address].
- Both read ports may address the same register, including the register being written; each resolves independently.
- DbgData = reg[DbgAddr] with x0 forced to 0; it never bypasses and shows the pre-edge value during a write cycle.
- BYPASS=0: reads return the stored value only; a written value is visible the cycle after the commit edge.
- Only one write port exists; no write collisions are possible.
- Inputs with RegWriteW=0 (pipeline bubbles) have no architectural effect, whatever the values of the other WB fields.
- Reset asserted mid-stream: the write presented in the reset cycle is lost. Normal commits resume on the first edge with rst_n=1.
- No X propagation: every output is driven from defined state after the first reset edge.

Test Plan:
- Reset, then RegWriteW=1, ResultSrcW=00, ALUResultW=0x12345678, RdW=5 for one edge → DbgAddr=5 gives DbgData=0x12345678; WriteCount=1.
- ResultSrcW=01 with ReadDataW=0xDEADBEEF, RdW=7; then ResultSrcW=10 with PCPlus4W=0x104, RdW=8; then ResultSrcW=11 with ALUResultW=0xA5, RdW=9 → x7=0xDEADBEEF, x8=0x104, x9=0xA5; WriteCount=3.
- RegWriteW=1, RdW=0, ALUResultW=0xFFFFFFFF → Rs1D=0 reads 0; WriteCount unchanged.
- Write-read same cycle, BYPASS=1: RdW=Rs1D=Rs2D=3, ResultW=0x55 → RD1D=RD2D=0x55 before the edge, while DbgData still shows the old x3 (0). With BYPASS=0, RD1D shows 0 until after the edge.
- Reset mid-stream: load x10=0x77, then assert rst_n=0 for one edge while RegWriteW=1, RdW=11 → x10=0, x11=0, WriteCount=0. The next write after deassert commits normally.
- Counter wrap (CNTW=4): 16 commits to x1 → WriteCount returns to 0. Bubbles with RegWriteW=0 interleaved → no count change.
